// File: rtl/tile_ctrl.sv
// Tile buffer controller: accepts shader pixel writes, clears the 8x8 tile and streams it out in raster order.
// Optional clear support is compiled in with the TILE_CTRL_CLEAR_EN macro.
module tile_ctrl #(
  parameter logic [23:0] CLEAR_VALUE = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_x,
  input  logic [2:0]  wr_y,
  input  logic [23:0] wr_data,
  input  logic        clear_req,
  input  logic        flush_req,
  output logic        busy,
  output logic        done,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_data,
  output logic [2:0]  pix_x,
  output logic [2:0]  pix_y,
  output logic        pix_last,
  output logic        tile_active,
  output logic        tile_w,
  output logic        tile_r,
  output logic [2:0]  tile_x,
  output logic [2:0]  tile_y,
  output logic [2:0]  tile_wx,
  output logic [2:0]  tile_wy,
  output logic [23:0] tile_v,
  input  logic [23:0] tile_o
);

  localparam int unsigned CW        = 7;
  localparam int unsigned AW        = 6;
  localparam logic [CW-1:0] N_PIX   = CW'(64);
  localparam logic [AW-1:0] LAST_A  = AW'(63);

`ifdef TILE_CTRL_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CLEAR = 2'd1, S_FLUSH = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FLUSH = 2'd2} state_t;
`endif

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_rc;
  logic            r_pv;
  logic            r_last;
  logic            r_done;
  logic [2:0]      r_px;
  logic [2:0]      r_py;
  logic            w_issue;
  logic            w_hs;
  logic            w_fin;
  logic            w_clear_end;

`ifdef TILE_CTRL_CLEAR_EN
  logic [AW-1:0]   r_wc;
  assign w_clear_end = (r_state == S_CLEAR) && (r_wc == LAST_A);
`else
  logic            w_unused_clear;
  assign w_unused_clear = clear_req ^ (^CLEAR_VALUE);
  assign w_clear_end    = 1'b0;
`endif

  // A read may issue only while addresses remain and the output slot is free or draining.
  assign w_hs    = r_pv & pix_ready;
  assign w_fin   = (r_state == S_FLUSH) & w_hs & r_last;
  assign w_issue = (r_state == S_FLUSH) & (r_rc != N_PIX) & (~r_pv | pix_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
`ifdef TILE_CTRL_CLEAR_EN
        if (clear_req)      w_next = S_CLEAR;
        else if (flush_req) w_next = S_FLUSH;
`else
        if (flush_req)      w_next = S_FLUSH;
`endif
      end
`ifdef TILE_CTRL_CLEAR_EN
      S_CLEAR: if (w_clear_end) w_next = S_IDLE;
`endif
      S_FLUSH: if (w_fin) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Counters, scanout slot and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rc   <= '0;
      r_pv   <= 1'b0;
      r_last <= 1'b0;
      r_done <= 1'b0;
      r_px   <= '0;
      r_py   <= '0;
`ifdef TILE_CTRL_CLEAR_EN
      r_wc   <= '0;
`endif
    end else begin
      r_done <= w_fin | w_clear_end;
      if (r_state == S_IDLE) r_rc <= '0;
      else if (w_issue)      r_rc <= CW'(r_rc + CW'(1));
`ifdef TILE_CTRL_CLEAR_EN
      if (r_state == S_CLEAR) r_wc <= AW'(r_wc + AW'(1));
      else                    r_wc <= '0;
`endif
      if (w_issue) begin
        r_pv   <= 1'b1;
        r_px   <= r_rc[2:0];
        r_py   <= r_rc[5:3];
        r_last <= (r_rc[AW-1:0] == LAST_A);
      end else if (w_hs) begin
        r_pv   <= 1'b0;
        r_last <= 1'b0;
      end
    end
  end

  assign pix_valid = r_pv;
  assign pix_last  = r_last;
  assign pix_x     = r_px;
  assign pix_y     = r_py;
  assign pix_data  = tile_o;
  assign done      = r_done;

  // Memory-side strobes are gated by rst_n so reset silences them immediately.
  always_comb begin
    wr_ready    = 1'b0;
    busy        = 1'b0;
    tile_active = 1'b0;
    tile_w      = 1'b0;
    tile_r      = 1'b0;
    tile_x      = '0;
    tile_y      = '0;
    tile_wx     = '0;
    tile_wy     = '0;
    tile_v      = '0;
    if (rst_n) begin
      tile_active = 1'b1;
      case (r_state)
        S_IDLE: begin
          wr_ready = 1'b1;
          tile_w   = wr_valid;
          tile_wx  = wr_x;
          tile_wy  = wr_y;
          tile_v   = wr_data;
        end
`ifdef TILE_CTRL_CLEAR_EN
        S_CLEAR: begin
          busy    = 1'b1;
          tile_w  = 1'b1;
          tile_wx = r_wc[2:0];
          tile_wy = r_wc[5:3];
          tile_v  = CLEAR_VALUE;
        end
`endif
        S_FLUSH: begin
          busy   = 1'b1;
          tile_r = w_issue;
          tile_x = r_rc[2:0];
          tile_y = r_rc[5:3];
        end
        default: ;
      endcase
    end
  end

endmodule
